ternary_weight_loader: RTL

TERNARY_WEIGHT_LOADER -- requirements
Module: ternary_weight_loader

---
 rtl/ternary_weight_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ternary_weight_loader.sv
// Byte-serial loader for a ternary (2-bit) weight bank feeding a matrix multiplier.
// Holds the bank stable and gates the multiplier enable so it only runs on a complete bank.
module ternary_weight_loader #(
   parameter int InLen     = 16,
   parameter int OutLen    = 8,
   parameter int ByteWidth = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          load_start,
   input  logic [ByteWidth-1:0]                          data_in,
   input  logic                                          data_valid,
   input  logic                                          run_req,
   input  logic                                          err_clr,
   output logic [2*InLen*OutLen-1:0]                     W,
   output logic                                          mult_en,
   output logic                                          weights_ready,
   output logic [$clog2(2*InLen*OutLen/ByteWidth)-1:0]   byte_count,
   output logic [1:0]                                    state,
   output logic                                          err,
   output logic                                          illegal
);
   localparam int NBYTES  = 2*InLen*OutLen/ByteWidth;
   localparam int CW      = $clog2(NBYTES);
   localparam int NFIELDS = ByteWidth/2;
   localparam logic [CW-1:0] LAST = CW'(NBYTES-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       count_reg, count_next;
   logic                ready_reg, ready_next;
   logic                mult_en_reg, mult_en_next;
   logic                err_reg, err_next;
   logic                illegal_reg, illegal_next;
   logic                wr_en;
   logic                err_set;
   logic                illegal_set;
   logic [ByteWidth-1:0] clean_byte;
   logic [NFIELDS-1:0]  bad_field;
   logic [ByteWidth-1:0] bank_reg [NBYTES];

   // Code 2'b10 has no ternary meaning; it is flushed to zero weight.
   genvar gi;
   generate
      for (gi = 0; gi < NFIELDS; gi++) begin : g_field
         assign bad_field[gi] = (data_in[2*gi +: 2] == 2'b10);
         assign clean_byte[2*gi +: 2] = bad_field[gi] ? 2'b00 : data_in[2*gi +: 2];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      ready_next = ready_reg;
      wr_en      = 1'b0;
      err_set    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load_start) begin
               state_next = LOAD;
               count_next = '0;
            end
         end
         LOAD: begin
            err_set = run_req;
            if (load_start) begin
               count_next = '0;
            end else if (data_valid) begin
               wr_en = 1'b1;
               if (count_reg == LAST) begin
                  state_next = READY;
                  ready_next = 1'b1;
                  count_next = '0;
               end else begin
                  count_next = count_reg + 1'b1;
               end
            end
         end
         READY: begin
            if (load_start) begin
               state_next = LOAD;
               count_next = '0;
               ready_next = 1'b0;
            end else if (run_req) begin
               state_next = RUN;
            end
         end
         RUN: begin
            err_set = load_start | data_valid;
            if (!run_req) begin
               state_next = READY;
            end
         end
         default: state_next = IDLE;
      endcase
      illegal_set  = wr_en & (|bad_field);
      // A setting event in the same cycle as err_clr leaves the flag set.
      err_next     = err_set | (err_reg & ~err_clr);
      illegal_next = illegal_set | (illegal_reg & ~err_clr);
      mult_en_next = (state_next == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         ready_reg   <= 1'b0;
         mult_en_reg <= 1'b0;
         err_reg     <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         ready_reg   <= ready_next;
         mult_en_reg <= mult_en_next;
         err_reg     <= err_next;
         illegal_reg <= illegal_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NBYTES; i++) begin
            bank_reg[i] <= '0;
         end
      end else if (wr_en) begin
         bank_reg[count_reg] <= clean_byte;
      end
   end

   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_bank
         assign W[ByteWidth*gi +: ByteWidth] = bank_reg[gi];
      end
   endgenerate

   assign mult_en       = mult_en_reg;
   assign weights_ready = ready_reg;
   assign byte_count    = count_reg;
   assign state         = state_reg;
   assign err           = err_reg;
   assign illegal       = illegal_reg;

endmodule
